glb_block_tx: RTL and testbench
===============================

GLB_BLOCK_TX -- requirements
Module: glb_block_tx

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, giving the words per block buffer.
REQ-002 The block SHALL have parameter ADDR_W, default 10, giving the buffer address width; DEPTH SHALL equal 2^ADDR_W.
REQ-003 The block SHALL have parameter NUM_BLOCKS, default 2, giving the blocks sent per run (legal values 1 or 2).
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port ld_en, input, 1: buffer write strobe.
REQ-007 Port ld_blk, input, 1: selects buffer 0 or 1 for the write.
REQ-008 Port ld_addr, input, ADDR_W: buffer write address.
REQ-009 Port ld_data, input, 16: buffer write data.
REQ-010 Port len_0 and port len_1, inputs, 16 each: word counts for block 0 and block 1, sampled on start.
REQ-011 Port start, input, 1: begins a run.
REQ-012 Port data, output, 16: stream word.
REQ-013 Port valid, output, 1: data is valid.
REQ-014 Port ready, input, 1: the downstream receiver accepts data.
REQ-015 Port busy, output, 1: a run is in progress.
REQ-016 Port done, output, 1: the run is complete.
REQ-017 Port stall_count, output, 32: backpressure cycle count (see Configuration).

Function
REQ-018 A transfer SHALL occur on a rising edge with valid=1 and ready=1; nothing else advances the stream.
REQ-019 The FSM SHALL have states IDLE, HDR0, DAT0, HDR1, DAT1 and FIN.
REQ-020 IDLE or FIN with start=1 SHALL latch min(len_0,DEPTH) and min(len_1,DEPTH), clear the word counter, and go to HDR0 next cycle.
REQ-021 In HDR0/HDR1 the block SHALL drive valid=1 and data=latched length of block 0/1.
REQ-022 A header transfer SHALL move to DAT0/DAT1 if the length is nonzero; otherwise it SHALL skip the data state.
REQ-023 In DAT0/DAT1 the block SHALL drive valid=1 and data=buffer[blk][cnt], with cnt incremented on each transfer.
REQ-024 When cnt reaches the block length, the block SHALL leave DAT0/DAT1 on the last transfer, with no idle cycle between words or blocks.
REQ-025 After block 0, the block SHALL go to HDR1 if NUM_BLOCKS==2, else to FIN; after block 1 it SHALL go to FIN.
REQ-026 Once valid=1 it SHALL NOT drop, and data SHALL NOT change, until the transfer occurs.
REQ-027 valid SHALL be 0 in IDLE and FIN.
REQ-028 busy SHALL be 1 in HDR0..DAT1; done SHALL be 1 in FIN and held until the next start or reset.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 ld_en while busy=1 SHALL be ignored; in IDLE/FIN writes SHALL take effect next cycle.
REQ-031 Length clamp: a len above DEPTH SHALL send DEPTH in the header and DEPTH data words.

Reset
REQ-032 rst_n=0 SHALL force IDLE immediately, regardless of clk, with valid=0, busy=0, done=0, data=0, cnt=0, stall_count=0 and latched lengths=0.
REQ-033 Reset mid-run SHALL abort the run without completing the in-flight word; buffer contents are not reset.

Configuration
REQ-034 With GLB_TX_STALL_CNT_EN defined, stall_count SHALL increment (saturating at 2^32-1) every cycle with valid=1 and ready=0, and clear on start.
REQ-035 Without GLB_TX_STALL_CNT_EN, stall_count SHALL be constant 0 and no counter logic SHALL be generated.

Verification
REQ-036 Load buffer0[0..3]=A0..A3, len_0=4, NUM_BLOCKS=1, ready=1, start -> data 0004,A0,A1,A2,A3 on 5 consecutive cycles, then done=1.
REQ-037 NUM_BLOCKS=2, len_0=2, len_1=3, ready toggling every cycle -> header/data sequence 0002,b0[0..1],0003,b1[0..2], with data held stable while ready=0.
REQ-038 len_0=0, len_1=1 -> 0000, 0001, b1[0], then done; no data word for block 0.
REQ-039 len_0=2000 with DEPTH=1024 -> header 0400, then 1024 data words.
REQ-040 rst_n low during DAT0 -> valid=0 and busy=0 in the same cycle; a new start replays from the header.
REQ-041 With GLB_TX_STALL_CNT_EN, ready held 0 for 7 cycles during HDR0 -> stall_count=7; without the macro -> stall_count=0.

Source files
------------

// File: rtl/glb_block_tx.sv
// Two-bank block transmitter: replays loaded buffers as header+data bursts.
// Latency: first header word is valid the cycle after an accepted start.
// Backpressure: valid/ready; valid and data hold steady until ready is seen.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   ld_en/ld_blk/ld_addr/ld_data   buffer write port (ignored while busy)
//   len_0, len_1            per-block word counts, sampled on start
//   start                   begin a run (only from idle or finished)
//   data/valid/ready        output stream
//   busy, done              run in progress / run finished (held)
//   stall_count             cycles with valid=1 and ready=0 since start
// Optional feature macro: GLB_TX_STALL_CNT_EN enables the stall counter;
// without it stall_count is tied to zero.
module glb_block_tx #(
   parameter int DEPTH      = 1024,
   parameter int ADDR_W     = 10,
   parameter int NUM_BLOCKS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_en,
   input  logic              ld_blk,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [15:0]       ld_data,
   input  logic [15:0]       len_0,
   input  logic [15:0]       len_1,
   input  logic              start,
   output logic [15:0]       data,
   output logic              valid,
   input  logic              ready,
   output logic              busy,
   output logic              done,
   output logic [31:0]       stall_count
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR0 = 3'd1,
      DAT0 = 3'd2,
      HDR1 = 3'd3,
      DAT1 = 3'd4,
      FIN  = 3'd5
   } state_t;

   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   state_t       state_q, state_d;
   logic [15:0]  len0_q, len1_q;
   logic [15:0]  cnt_q;
   logic         cnt_clr, cnt_inc;
   logic         start_ok;
   logic         last0, last1;
   logic [15:0]  mem0 [DEPTH];
   logic [15:0]  mem1 [DEPTH];
   logic [ADDR_W-1:0] rd_addr;

   function automatic logic [15:0] clamp_len(input logic [15:0] l);
      if ({1'b0, l} > DEPTH_L) clamp_len = DEPTH_L[15:0];
      else                     clamp_len = l;
   endfunction

   // Block 0 continues to block 1 only in two-block builds.
   localparam state_t AFTER0 = (NUM_BLOCKS == 2) ? HDR1 : FIN;

   assign start_ok = start && ((state_q == IDLE) || (state_q == FIN));
   assign rd_addr  = cnt_q[ADDR_W-1:0];
   assign last0    = ((cnt_q + 16'd1) == len0_q);
   assign last1    = ((cnt_q + 16'd1) == len1_q);
   assign done     = (state_q == FIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      valid   = 1'b0;
      busy    = 1'b0;
      data    = 16'h0000;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         IDLE, FIN: begin
            if (start_ok) state_d = HDR0;
         end
         HDR0: begin
            valid = 1'b1;
            busy  = 1'b1;
            data  = len0_q;
            if (ready) state_d = (len0_q != 16'd0) ? DAT0 : AFTER0;
         end
         DAT0: begin
            valid = 1'b1;
            busy  = 1'b1;
            data  = mem0[rd_addr];
            if (ready) begin
               if (last0) begin
                  cnt_clr = 1'b1;
                  state_d = AFTER0;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         HDR1: begin
            valid = 1'b1;
            busy  = 1'b1;
            data  = len1_q;
            if (ready) state_d = (len1_q != 16'd0) ? DAT1 : FIN;
         end
         DAT1: begin
            valid = 1'b1;
            busy  = 1'b1;
            data  = mem1[rd_addr];
            if (ready) begin
               if (last1) begin
                  cnt_clr = 1'b1;
                  state_d = FIN;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len0_q <= 16'd0;
         len1_q <= 16'd0;
         cnt_q  <= 16'd0;
      end else if (start_ok) begin
         len0_q <= clamp_len(len_0);
         len1_q <= clamp_len(len_1);
         cnt_q  <= 16'd0;
      end else if (cnt_clr) begin
         cnt_q  <= 16'd0;
      end else if (cnt_inc) begin
         cnt_q  <= cnt_q + 16'd1;
      end
   end

   // Buffers are frozen during a run so the streamed words cannot change
   // under backpressure; contents survive reset.
   always_ff @(posedge clk) begin
      if (ld_en && !busy) begin
         if (ld_blk) mem1[ld_addr] <= ld_data;
         else        mem0[ld_addr] <= ld_data;
      end
   end

`ifdef GLB_TX_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= 32'd0;
      end else if (start_ok) begin
         stall_q <= 32'd0;
      end else if (valid && !ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_count = stall_q;
`else
   assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_glb_block_tx.sv
module tb_glb_block_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_en_a = 1'b0, ld_en_b = 1'b0;
   logic        ld_blk = 1'b0;
   logic [9:0]  ld_addr = '0;
   logic [15:0] ld_data = '0;
   logic [15:0] len_0 = '0, len_1 = '0;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic        ready = 1'b0;

   logic [15:0] data_a, data_b;
   logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;
   logic [31:0] stall_a, stall_b;

   int vec  = 0;
   int errs = 0;

   // Reference buffer image, shared by both instances.
   logic [15:0] m0 [1024];
   logic [15:0] m1 [1024];

   always #5 clk = ~clk;

   glb_block_tx #(.DEPTH(1024), .ADDR_W(10), .NUM_BLOCKS(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .ld_en(ld_en_a), .ld_blk(ld_blk), .ld_addr(ld_addr),
      .ld_data(ld_data), .len_0(len_0), .len_1(len_1), .start(start_a),
      .data(data_a), .valid(valid_a), .ready(ready), .busy(busy_a), .done(done_a),
      .stall_count(stall_a));

   glb_block_tx #(.DEPTH(1024), .ADDR_W(10), .NUM_BLOCKS(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ld_en(ld_en_b), .ld_blk(ld_blk), .ld_addr(ld_addr),
      .ld_data(ld_data), .len_0(len_0), .len_1(len_1), .start(start_b),
      .data(data_b), .valid(valid_b), .ready(ready), .busy(busy_b), .done(done_b),
      .stall_count(stall_b));

   task automatic load_rand(input int n0, input int n1);
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < ((b == 0) ? n0 : n1); i++) begin
            ld_en_a = 1'b1;
            ld_en_b = 1'b1;
            ld_blk  = b[0];
            ld_addr = 10'(i);
            ld_data = 16'($urandom);
            if (b == 0) m0[i] = ld_data;
            else        m1[i] = ld_data;
            @(negedge clk);
         end
      end
      ld_en_a = 1'b0;
      ld_en_b = 1'b0;
   endtask

   // Runs one transfer on the chosen instance and checks it word by word.
   // rmode: 0 always ready, 1 toggling, 2 seven low cycles then ready, 3 random.
   task automatic run_stream(input bit use_b, input int l0, input int l1,
                             input int rmode, input bit poke, input string name);
      logic [15:0] exp_q[$];
      int n0, n1, total, cyc, stalls, exp_stall;
      bit fin, prev_hold;
      logic [15:0] prev_d, d, e;
      logic v, bz, dn;
      logic [31:0] sc;

      n0 = (l0 > 1024) ? 1024 : l0;
      n1 = (l1 > 1024) ? 1024 : l1;
      exp_q.push_back(16'(n0));
      for (int i = 0; i < n0; i++) exp_q.push_back(m0[i]);
      if (!use_b) begin
         exp_q.push_back(16'(n1));
         for (int i = 0; i < n1; i++) exp_q.push_back(m1[i]);
      end
      total = exp_q.size();

      len_0 = 16'(l0);
      len_1 = 16'(l1);
      if (use_b) start_b = 1'b1;
      else       start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;

      cyc = 0; stalls = 0; fin = 0; prev_hold = 0; prev_d = '0;
      while (!fin && cyc < 20000) begin
         case (rmode)
            0:       ready = 1'b1;
            1:       ready = cyc[0];
            2:       ready = (cyc >= 7);
            default: ready = 1'($urandom);
         endcase
         v  = use_b ? valid_b : valid_a;
         d  = use_b ? data_b  : data_a;
         bz = use_b ? busy_b  : busy_a;
         dn = use_b ? done_b  : done_a;
         if (dn) begin
            fin = 1;
         end else begin
            vec++;
            if (v !== 1'b1 || bz !== 1'b1) begin
               errs++;
               $display("FAIL %s run_gap cyc=%0d valid=%b busy=%b required valid=1 busy=1",
                        name, cyc, v, bz);
            end
            if (prev_hold) begin
               vec++;
               if (d !== prev_d) begin
                  errs++;
                  $display("FAIL %s hold_stable cyc=%0d data=%h required %h", name, cyc, d, prev_d);
               end
            end
            if (v && ready) begin
               vec++;
               if (exp_q.size() == 0) begin
                  errs++;
                  $display("FAIL %s extra_word data=%h required no transfer", name, d);
               end else begin
                  e = exp_q.pop_front();
                  if (d !== e) begin
                     errs++;
                     $display("FAIL %s word%0d data=%h required %h", name,
                              total - exp_q.size() - 1, d, e);
                  end
               end
            end else if (v) begin
               stalls++;
            end
            prev_hold = v && !ready;
            prev_d    = d;
            if (poke && !use_b) begin
               // Writes and starts during the run must have no effect.
               ld_en_a = 1'($urandom);
               ld_blk  = 1'($urandom);
               ld_addr = 10'($urandom_range(0, 40));
               ld_data = 16'($urandom);
               start_a = bz & 1'($urandom);
               len_0   = 16'($urandom);
               len_1   = 16'($urandom);
            end
            @(negedge clk);
            cyc++;
         end
      end
      ld_en_a = 1'b0;
      start_a = 1'b0;

      vec++;
      if (!fin) begin
         errs++;
         $display("FAIL %s timeout cycles=%0d required done", name, cyc);
      end
      vec++;
      if (exp_q.size() != 0) begin
         errs++;
         $display("FAIL %s missing_words left=%0d required 0", name, exp_q.size());
      end
      if (rmode == 0) begin
         vec++;
         if (cyc != total) begin
            errs++;
            $display("FAIL %s back_to_back cycles=%0d required %0d", name, cyc, total);
         end
      end
      v  = use_b ? valid_b : valid_a;
      bz = use_b ? busy_b  : busy_a;
      sc = use_b ? stall_b : stall_a;
      vec++;
      if (v !== 1'b0 || bz !== 1'b0) begin
         errs++;
         $display("FAIL %s fin_state valid=%b busy=%b required 0 0", name, v, bz);
      end
`ifdef GLB_TX_STALL_CNT_EN
      exp_stall = stalls;
`else
      exp_stall = 0;
`endif
      vec++;
      if (sc !== 32'(exp_stall)) begin
         errs++;
         $display("FAIL %s stall_count=%0d required %0d", name, sc, exp_stall);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      vec++;
      if ({valid_a, busy_a, done_a, data_a, stall_a} !== 51'd0 ||
          {valid_b, busy_b, done_b, data_b, stall_b} !== 51'd0) begin
         errs++;
         $display("FAIL %s a=%b%b%b/%h/%0d b=%b%b%b/%h/%0d required all zero", name,
                  valid_a, busy_a, done_a, data_a, stall_a,
                  valid_b, busy_b, done_b, data_b, stall_b);
      end
   endtask

   task automatic test_reset();
      #3;
      check_reset_outputs("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("after_release");
   endtask

   task automatic test_single_block();
      run_stream(1'b1, 4, 9, 0, 1'b0, "single_block");
   endtask

   task automatic test_toggle_ready();
      run_stream(1'b0, 2, 3, 1, 1'b0, "toggle_ready");
   endtask

   task automatic test_zero_len();
      run_stream(1'b0, 0, 1, 3, 1'b0, "zero_len");
      repeat (3) @(negedge clk);
      vec++;
      if (done_a !== 1'b1 || valid_a !== 1'b0) begin
         errs++;
         $display("FAIL done_held done=%b valid=%b required 1 0", done_a, valid_a);
      end
      run_stream(1'b0, 0, 0, 0, 1'b0, "both_zero");
   endtask

   task automatic test_stall();
      run_stream(1'b0, 3, 2, 2, 1'b0, "stall_hdr0");
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++) begin
         run_stream(1'($urandom), $urandom_range(0, 32), $urandom_range(0, 32),
                    3, 1'b1, "random");
      end
   endtask

   task automatic test_mid_reset();
      len_0 = 16'd20;
      len_1 = 16'd5;
      ready = 1'b1;
      start_a = 1'b1;
      start_b = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      repeat (2) @(negedge clk);
      vec++;
      if (valid_a !== 1'b1 || busy_a !== 1'b1) begin
         errs++;
         $display("FAIL mid_run_active valid=%b busy=%b required 1 1", valid_a, busy_a);
      end
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_stream(1'b0, 6, 4, 0, 1'b0, "replay_after_reset");
   endtask

   task automatic test_clamp();
      load_rand(1024, 1024);
      run_stream(1'b0, 2000, 1025, 3, 1'b0, "clamp");
      run_stream(1'b1, 16'hFFFF, 3, 0, 1'b0, "clamp_single");
   endtask

   initial begin
      test_reset();
      load_rand(32, 32);
      test_single_block();
      test_toggle_ready();
      test_zero_len();
      test_stall();
      test_random();
      test_mid_reset();
      test_clamp();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
